// File: rtl/baggage_drop_seq.sv
// baggage_drop_seq
//   Sequential baggage-drop decision datapath. It averages NUM_SENSORS
//   altitude readings (a reading of 0 is a faulty channel and is skipped),
//   rounds the average half up, derives the fall time from a bit-serial
//   square root, compares it with t_lim and drives the "drOP"/"HOLd" digits.
//
//   Ports
//     clk, rst_n            rising-edge clock, asynchronous active-low reset
//     start                 request a measurement (accepted only when not busy)
//     sensors               flat bus, channel i = [i*SENSOR_W +: SENSOR_W]
//     t_lim, drop_en        time limit and drop permission, captured with start
//     busy                  from the cycle after start is accepted through done
//     done                  one-cycle pulse, results valid from this cycle
//     t_act                 fall time = floor(sqrt(height << 2*FRAC_BITS)) >> 1
//     sensor_fault          every channel read 0
//     drop_activated        drop decision
//     seven_seg1..4         digits left to right, {g,f,e,d,c,b,a}, active-high
module baggage_drop_seq #(
  parameter int NUM_SENSORS = 4,
  parameter int SENSOR_W    = 8,
  parameter int TLIM_W      = 16,
  parameter int FRAC_BITS   = 8,
  localparam int ROOT_W     = SENSOR_W/2 + FRAC_BITS
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [NUM_SENSORS*SENSOR_W-1:0] sensors,
  input  logic [TLIM_W-1:0]               t_lim,
  input  logic                            drop_en,
  output logic                            busy,
  output logic                            done,
  output logic [ROOT_W-1:0]               t_act,
  output logic                            sensor_fault,
  output logic                            drop_activated,
  output logic [6:0]                      seven_seg1,
  output logic [6:0]                      seven_seg2,
  output logic [6:0]                      seven_seg3,
  output logic [6:0]                      seven_seg4
);
  localparam int CNT_W = $clog2(NUM_SENSORS+1);
  localparam int SUM_W = SENSOR_W + CNT_W;
  localparam int RAD_W = 2*ROOT_W;
  localparam int CMP_W = (ROOT_W > TLIM_W) ? ROOT_W : TLIM_W;
  localparam int MAX_A = (NUM_SENSORS > SENSOR_W) ? NUM_SENSORS : SENSOR_W;
  localparam int MAX_S = (MAX_A > ROOT_W) ? MAX_A : ROOT_W;
  localparam int CTR_W = $clog2(MAX_S);

  localparam logic [6:0] SEG_D = 7'b1011110;
  localparam logic [6:0] SEG_R = 7'b1010000;
  localparam logic [6:0] SEG_O = 7'b1011100;
  localparam logic [6:0] SEG_P = 7'b1110011;
  localparam logic [6:0] SEG_H = 7'b1110100;
  localparam logic [6:0] SEG_L = 7'b0111000;

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_DIV, S_SQRT, S_DECIDE} state_t;

  state_t                          state_q, state_d;
  logic [CTR_W-1:0]                step_q, step_d;
  logic [NUM_SENSORS*SENSOR_W-1:0] sens_q, sens_d;
  logic [TLIM_W-1:0]               tlim_q, tlim_d;
  logic                            den_q, den_d;
  logic [SUM_W-1:0]                sum_q, sum_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            fault_q, fault_d;
  logic [CNT_W-1:0]                drem_q, drem_d;
  logic [SENSOR_W-1:0]             quo_q, quo_d;
  logic [RAD_W-1:0]                rad_q, rad_d;
  logic [ROOT_W+1:0]               srem_q, srem_d;
  logic [ROOT_W-1:0]               root_q, root_d;
  logic                            busy_q, busy_d, done_q, done_d;
  logic [ROOT_W-1:0]               t_act_q, t_act_d;
  logic                            sfault_q, sfault_d, drop_q, drop_d;
  logic [6:0]                      seg1_q, seg1_d, seg2_q, seg2_d;
  logic [6:0]                      seg3_q, seg3_d, seg4_q, seg4_d;

  // datapath temporaries
  logic [SENSOR_W-1:0] ch;
  logic [SUM_W-1:0]    sum_nx, num;
  logic [CNT_W-1:0]    cnt_nx;
  logic [CNT_W:0]      rsh;
  logic [SENSOR_W-1:0] quo_nx;
  logic [ROOT_W+3:0]   ssh, trial;
  logic [ROOT_W-1:0]   tact_nx;
  logic                drop_nx;

  always_comb begin
    state_d  = state_q;  step_d  = step_q;  sens_d  = sens_q;   tlim_d = tlim_q;
    den_d    = den_q;    sum_d   = sum_q;   cnt_d   = cnt_q;    fault_d = fault_q;
    drem_d   = drem_q;   quo_d   = quo_q;   rad_d   = rad_q;    srem_d = srem_q;
    root_d   = root_q;   busy_d  = busy_q;  done_d  = 1'b0;     t_act_d = t_act_q;
    sfault_d = sfault_q; drop_d  = drop_q;
    seg1_d   = seg1_q;   seg2_d  = seg2_q;  seg3_d  = seg3_q;   seg4_d = seg4_q;
    ch      = sens_q[SENSOR_W-1:0];
    sum_nx  = sum_q;
    cnt_nx  = cnt_q;
    num     = '0;
    rsh     = {drem_q, quo_q[SENSOR_W-1]};
    quo_nx  = '0;
    ssh     = {srem_q, rad_q[RAD_W-1 -: 2]};
    trial   = {2'b00, root_q, 2'b01};
    tact_nx = ROOT_W'(root_q >> 1);
    drop_nx = den_q & ~fault_q & (CMP_W'(tact_nx) <= CMP_W'(tlim_q));

    unique case (state_q)
      S_IDLE: begin
        // busy stays high through the done cycle so start is ignored there
        if (start && !busy_q) begin
          sens_d  = sensors;
          tlim_d  = t_lim;
          den_d   = drop_en;
          sum_d   = '0;
          cnt_d   = '0;
          step_d  = CTR_W'(NUM_SENSORS-1);
          busy_d  = 1'b1;
          state_d = S_ACCUM;
        end else if (done_q) begin
          busy_d = 1'b0;
        end
      end
      S_ACCUM: begin
        if (ch != '0) begin
          sum_nx = sum_q + SUM_W'(ch);
          cnt_nx = cnt_q + CNT_W'(1);
        end
        sum_d  = sum_nx;
        cnt_d  = cnt_nx;
        sens_d = sens_q >> SENSOR_W;
        if (step_q == '0) begin
          // Quotient fits SENSOR_W bits, so the bits above SENSOR_W are already
          // smaller than cnt and can seed the remainder directly.
          num     = sum_nx + SUM_W'(cnt_nx >> 1);
          drem_d  = num[SUM_W-1:SENSOR_W];
          quo_d   = num[SENSOR_W-1:0];
          fault_d = (cnt_nx == '0);
          step_d  = CTR_W'(SENSOR_W-1);
          state_d = S_DIV;
        end else begin
          step_d = step_q - CTR_W'(1);
        end
      end
      S_DIV: begin
        if (rsh >= {1'b0, cnt_q}) begin
          drem_d = CNT_W'(rsh - {1'b0, cnt_q});
          quo_nx = {quo_q[SENSOR_W-2:0], 1'b1};
        end else begin
          drem_d = rsh[CNT_W-1:0];
          quo_nx = {quo_q[SENSOR_W-2:0], 1'b0};
        end
        quo_d = quo_nx;
        if (step_q == '0) begin
          // a zero divisor leaves garbage in the quotient; height is forced 0
          rad_d   = fault_q ? '0 : (RAD_W'(quo_nx) << (2*FRAC_BITS));
          srem_d  = '0;
          root_d  = '0;
          step_d  = CTR_W'(ROOT_W-1);
          state_d = S_SQRT;
        end else begin
          step_d = step_q - CTR_W'(1);
        end
      end
      S_SQRT: begin
        // restoring root: one result bit per cycle, two radicand bits consumed
        if (ssh >= trial) begin
          srem_d = (ROOT_W+2)'(ssh - trial);
          root_d = {root_q[ROOT_W-2:0], 1'b1};
        end else begin
          srem_d = ssh[ROOT_W+1:0];
          root_d = {root_q[ROOT_W-2:0], 1'b0};
        end
        rad_d = rad_q << 2;
        if (step_q == '0) state_d = S_DECIDE;
        else              step_d  = step_q - CTR_W'(1);
      end
      S_DECIDE: begin
        t_act_d  = tact_nx;
        sfault_d = fault_q;
        drop_d   = drop_nx;
        done_d   = 1'b1;
        if (drop_nx) begin
          seg1_d = SEG_D; seg2_d = SEG_R; seg3_d = SEG_O; seg4_d = SEG_P;
        end else begin
          seg1_d = SEG_H; seg2_d = SEG_O; seg3_d = SEG_L; seg4_d = SEG_D;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE; step_q <= '0; sens_q <= '0; tlim_q <= '0; den_q <= 1'b0;
      sum_q   <= '0; cnt_q <= '0; fault_q <= 1'b0; drem_q <= '0; quo_q <= '0;
      rad_q   <= '0; srem_q <= '0; root_q <= '0; busy_q <= 1'b0; done_q <= 1'b0;
      t_act_q <= '0; sfault_q <= 1'b0; drop_q <= 1'b0;
      seg1_q  <= '0; seg2_q <= '0; seg3_q <= '0; seg4_q <= '0;
    end else begin
      state_q <= state_d; step_q <= step_d; sens_q <= sens_d; tlim_q <= tlim_d;
      den_q   <= den_d; sum_q <= sum_d; cnt_q <= cnt_d; fault_q <= fault_d;
      drem_q  <= drem_d; quo_q <= quo_d; rad_q <= rad_d; srem_q <= srem_d;
      root_q  <= root_d; busy_q <= busy_d; done_q <= done_d; t_act_q <= t_act_d;
      sfault_q <= sfault_d; drop_q <= drop_d;
      seg1_q  <= seg1_d; seg2_q <= seg2_d; seg3_q <= seg3_d; seg4_q <= seg4_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign t_act          = t_act_q;
  assign sensor_fault   = sfault_q;
  assign drop_activated = drop_q;
  assign seven_seg1     = seg1_q;
  assign seven_seg2     = seg2_q;
  assign seven_seg3     = seg3_q;
  assign seven_seg4     = seg4_q;
endmodule

// File: tb/tb_baggage_drop_seq.sv
// Bench for baggage_drop_seq (default parameters): directed cases, a
// mid-operation reset, then randomized traffic compared every cycle against a
// behavioural model built from averaging/rounding/sqrt arithmetic.
module tb_baggage_drop_seq;
  localparam int LAT = 25;
  localparam logic [27:0] DROP_SEGS = {7'b1011110, 7'b1010000, 7'b1011100, 7'b1110011};
  localparam logic [27:0] HOLD_SEGS = {7'b1110100, 7'b1011100, 7'b0111000, 7'b1011110};

  logic        clk, rst_n, start, drop_en;
  logic [31:0] sensors;
  logic [15:0] t_lim;
  logic        busy, done, sensor_fault, drop_activated;
  logic [11:0] t_act;
  logic [6:0]  seven_seg1, seven_seg2, seven_seg3, seven_seg4;

  int total = 0;
  int bad   = 0;

  baggage_drop_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sensors(sensors), .t_lim(t_lim),
    .drop_en(drop_en), .busy(busy), .done(done), .t_act(t_act),
    .sensor_fault(sensor_fault), .drop_activated(drop_activated),
    .seven_seg1(seven_seg1), .seven_seg2(seven_seg2),
    .seven_seg3(seven_seg3), .seven_seg4(seven_seg4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Result packed as {drop, fault, t_act[11:0]}.
  function automatic logic [13:0] ref_model(input logic [31:0] s, input logic [15:0] tl,
                                            input logic de);
    int sum, n, h, r, ta;
    longint v;
    sum = 0; n = 0;
    for (int i = 0; i < 4; i++) begin
      int c;
      c = int'(s[i*8 +: 8]);
      if (c != 0) begin sum += c; n++; end
    end
    if (n == 0) return {1'b0, 1'b1, 12'd0};
    h  = (2*sum + n) / (2*n);          // nearest integer, halves go up
    v  = longint'(h) * 65536;
    r  = int'($floor($sqrt(real'(v))));
    while (longint'(r)*r > v) r--;
    while (longint'(r+1)*(r+1) <= v) r++;
    ta = r / 2;
    return {de && (ta <= int'(tl)), 1'b0, 12'(ta)};
  endfunction

  // Transaction-level model: accept, count LAT edges, then publish.
  logic        m_busy, m_done, m_valid;
  int          m_left;
  logic [13:0] m_pend, m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_valid <= 1'b0; m_left <= 0;
      m_pend <= '0; m_res <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_done) m_busy <= 1'b0;
      if (!m_busy && start) begin
        m_busy <= 1'b1;
        m_left <= LAT;
        m_pend <= ref_model(sensors, t_lim, drop_en);
      end else if (m_busy && m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1; m_res <= m_pend; m_valid <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [27:0] esegs;
    esegs = !m_valid ? 28'd0 : (m_res[13] ? DROP_SEGS : HOLD_SEGS);
    chk("cyc_done", done, m_done);
    chk("cyc_busy", busy, m_busy);
    chk("cyc_tact", t_act, m_res[11:0]);
    chk("cyc_fault", sensor_fault, m_res[12]);
    chk("cyc_drop", drop_activated, m_res[13]);
    chk("cyc_segs", {seven_seg1, seven_seg2, seven_seg3, seven_seg4}, esegs);
  end

  // Caller sits just after a posedge with the DUT idle.
  task automatic run_op(input string nm, input logic [31:0] s, input logic [15:0] tl,
                        input logic de, input int et, input bit ed, input bit ef);
    int lat;
    bit seen;
    sensors = s; t_lim = tl; drop_en = de; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 0; seen = 0;
    while (!seen && lat < 60) begin
      @(posedge clk); lat++;
      #1 if (done) seen = 1;
    end
    chk({nm, "_latency"}, lat, LAT);
    chk({nm, "_tact"}, t_act, et);
    chk({nm, "_drop"}, drop_activated, ed);
    chk({nm, "_fault"}, sensor_fault, ef);
    chk({nm, "_segs"}, {seven_seg1, seven_seg2, seven_seg3, seven_seg4},
        ed ? DROP_SEGS : HOLD_SEGS);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [13:0] r;
    int ndone;
    rst_n = 1'b1; start = 1'b0; sensors = '0; t_lim = '0; drop_en = 1'b0;

    // pin the model to hand-worked values
    r = ref_model({8'd100, 8'd100, 8'd100, 8'd100}, 16'd1280, 1'b1);
    chk("model_100", r, {1'b1, 1'b0, 12'd1280});
    r = ref_model({8'd100, 8'd100, 8'd100, 8'd100}, 16'd1279, 1'b1);
    chk("model_100_lim", r, {1'b0, 1'b0, 12'd1280});
    r = ref_model({8'd0, 8'd64, 8'd64, 8'd0}, 16'd2000, 1'b1);
    chk("model_64", r, {1'b1, 1'b0, 12'd1024});
    r = ref_model({8'd1, 8'd2, 8'd0, 8'd0}, 16'd2000, 1'b1);
    chk("model_round", r, {1'b1, 1'b0, 12'd181});
    r = ref_model(32'd0, 16'd2000, 1'b1);
    chk("model_fault", r, {1'b0, 1'b1, 12'd0});
    r = ref_model(32'hFFFF_FFFF, 16'd0, 1'b1);
    chk("model_max", r, {1'b0, 1'b0, 12'd2043});

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_segs", {seven_seg1, seven_seg2, seven_seg3, seven_seg4}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("t1", {4{8'd100}}, 16'd1280, 1'b1, 1280, 1, 0);
    run_op("t2", {4{8'd100}}, 16'd1279, 1'b1, 1280, 0, 0);
    run_op("t3", {4{8'd100}}, 16'd1280, 1'b0, 1280, 0, 0);
    run_op("t4a", {8'd0, 8'd64, 8'd64, 8'd0}, 16'd2000, 1'b1, 1024, 1, 0);
    run_op("t4b", {8'd0, 8'd0, 8'd2, 8'd1}, 16'd2000, 1'b1, 181, 1, 0);
    run_op("t5a", 32'd0, 16'hFFFF, 1'b1, 0, 0, 1);
    run_op("t5b", 32'hFFFF_FFFF, 16'd2043, 1'b1, 2043, 1, 0);

    // second start mid-operation and input changes are ignored
    sensors = {4{8'd100}}; t_lim = 16'd1280; drop_en = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 3) begin sensors = 32'd0; t_lim = 16'd0; drop_en = 1'b0; end
      if (k == 9) start = 1'b1;
      if (k == 10) start = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        chk("t6_done_edge", k, LAT);
        chk("t6_tact", t_act, 1280);
        chk("t6_drop", drop_activated, 1);
      end
    end
    chk("t6_done_count", ndone, 1);

    // reset mid-operation
    sensors = {4{8'd100}}; t_lim = 16'd1280; drop_en = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (11) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t6r_busy", busy, 0);
    chk("t6r_tact", t_act, 0);
    chk("t6r_drop", drop_activated, 0);
    chk("t6r_segs", {seven_seg1, seven_seg2, seven_seg3, seven_seg4}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    ndone = 0;
    repeat (40) begin @(posedge clk); #1 if (done) ndone++; end
    chk("t6r_no_done", ndone, 0);
    run_op("t6r_again", {8'd0, 8'd0, 8'd2, 8'd1}, 16'd181, 1'b1, 181, 1, 0);

    // randomized traffic; the per-cycle compare does the checking
    repeat (1500) begin
      logic [31:0] s;
      for (int i = 0; i < 4; i++)
        s[i*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if ($urandom_range(0, 7) == 0) s = 32'd0;
      sensors = s;
      t_lim   = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 2100)) : 16'($urandom);
      drop_en = ($urandom_range(0, 3) != 0);
      start   = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
